// File: rtl/spi_slave_cpol0_cpha0.sv
// rtl/spi_slave_cpol0_cpha0.sv - SPI mode-0 slave, 8-bit full-duplex frames, oversampled in the clk domain
//
// Purpose: receives MSB-first bytes on mosi at sclk rising edges. It shifts
// transmit bytes out on miso, and miso changes after sclk falling edges.
// cs_n, sclk and mosi are asynchronous to clk and are synchronized before
// use. Transmit bytes are staged in a one-deep holding register.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   cs_n, sclk, mosi   asynchronous SPI inputs from the master
//   miso, miso_oe      serial data to the master and its tristate enable
//   tx_data, tx_load   holding-register write (tx_load is a 1-cycle strobe)
//   tx_ready           holding register empty
//   tx_underrun        1-cycle pulse: a byte slot started with nothing staged
//   rx_data, rx_valid  last complete received byte, 1-cycle update pulse
//   busy               synchronized cs_n is low
module spi_slave_cpol0_cpha0 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  // vld_q fills with ones after reset. When its top bit is set, cs_prev_q holds
  // a real sample of cs_n and no longer holds the reset value.
  logic [SYNC_STAGES:0]   vld_q;
  logic                   armed_q;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [6:0]  rx_sh_q;
  logic [7:0]  tx_sh_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        miso_q, miso_oe_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, underrun_q;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic arm_d, start_d, boundary_d, reload_d;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall   =  cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q &  cs_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  // The reset value of the synchronizer is "deselected". If cs_n is held low
  // through reset, the chain settles 1->0 and looks like a false falling edge.
  // A frame is accepted only after a real high level of cs_n is seen.
  assign arm_d = armed_q | (vld_q[SYNC_STAGES] & cs_prev_q);

  assign start_d    = (state_q == ST_IDLE) & cs_fall & arm_d;
  assign boundary_d = (state_q == ST_ACTIVE) & ~cs_rise & sclk_fall & (cnt_q == 3'd0);
  assign reload_d   = start_d | boundary_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      vld_q       <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= arm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      // A load on the reload cycle is not seen by the reload. The reload uses
      // the prior contents (or finds the register empty), and the new byte
      // stays in the holding register for the next slot.
      if (tx_load) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (reload_d && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (cs_rise) begin
        state_q   <= ST_IDLE;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        cnt_q     <= 3'd0;
      end else if (state_q == ST_IDLE) begin
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        cnt_q     <= 3'd0;
        if (start_d) begin
          state_q   <= ST_ACTIVE;
          miso_oe_q <= 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          rx_sh_q <= {rx_sh_q[5:0], mosi_s};
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_q  <= {rx_sh_q, mosi_s};
            rx_valid_q <= 1'b1;
          end
        end else if (sclk_fall && cnt_q != 3'd0) begin
          tx_sh_q <= {tx_sh_q[6:0], 1'b0};
          miso_q  <= tx_sh_q[6];
        end
      end

      // The frame start and each byte boundary share one reload path.
      // The assignments here override the miso value set above.
      if (reload_d) begin
        if (hold_full_q) begin
          tx_sh_q <= hold_q;
          miso_q  <= hold_q[7];
        end else begin
          tx_sh_q    <= 8'd0;
          miso_q     <= 1'b0;
          underrun_q <= 1'b1;
        end
      end
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign tx_underrun = underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_slave_cpol0_cpha0.sv
// tb/tb_spi_slave_cpol0_cpha0.sv - self-checking bench for the SPI mode-0 slave
module tb_spi_slave_cpol0_cpha0;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst, cs_n, sclk, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready, tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid, busy;

  always #5 clk = ~clk;

  spi_slave_cpol0_cpha0 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  int checks = 0;
  int passed = 0;
  int rx_cnt = 0;
  int unr_cnt = 0;
  logic [7:0] rx_exp_q[$];

  typedef struct {
    logic       do_load;
    logic [7:0] load_val;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    int         exp_unr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // Scoreboard side: each rx_valid pulse consumes the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (rx_exp_q.size() == 0) begin
        checks++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
      end else begin
        check("rx_data_scoreboard", rx_data, rx_exp_q.pop_front());
      end
    end
    if (tx_underrun) unr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
  endtask

  // Transfer one byte as the master. The master samples miso at each rising
  // sclk edge. A byte that ends the frame leaves sclk high.
  task automatic xfer_byte(input logic [7:0] mo, input logic end_frame,
                           input logic mid_load, input logic [7:0] mid_val,
                           output logic [7:0] mi);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      wait_clks(HALF);
      if (i == 0) rx_exp_q.push_back(mo);
      sclk = 1'b1;
      m[i] = miso;
      if (mid_load && i == 4) begin
        load(mid_val);
        wait_clks(HALF - 1);
      end else begin
        wait_clks(HALF);
      end
      if (!(end_frame && i == 0)) sclk = 1'b0;
    end
    mi = m;
  endtask

  task automatic end_frame_seq;
    cs_n = 1'b1;
    wait_clks(6);
    sclk = 1'b0;
    wait_clks(HALF);
  endtask

  initial begin
    logic [7:0] m0, m1;
    int rx0, u0, k;

    vecs[0] = '{do_load: 1'b1, load_val: 8'hA5, mo: 8'h3C, exp_mi: 8'hA5, exp_unr: 0};
    vecs[1] = '{do_load: 1'b0, load_val: 8'h00, mo: 8'h5A, exp_mi: 8'h00, exp_unr: 1};
    vecs[2] = '{do_load: 1'b1, load_val: 8'hFF, mo: 8'h00, exp_mi: 8'hFF, exp_unr: 0};
    vecs[3] = '{do_load: 1'b1, load_val: 8'h00, mo: 8'hFF, exp_mi: 8'h00, exp_unr: 0};

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_data = 8'h00; tx_load = 1'b0;
    wait_clks(3);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clks(6);

    // Single-byte frames.
    for (int v = 0; v < 4; v++) begin
      rx0 = rx_cnt; u0 = unr_cnt;
      if (vecs[v].do_load) begin
        load(vecs[v].load_val);
        check("tx_ready_after_load", tx_ready, 0);
      end
      cs_n = 1'b0;
      xfer_byte(vecs[v].mo, 1'b1, 1'b0, 8'h00, m0);
      check("busy_in_frame", busy, 1);
      end_frame_seq();
      check("vec_miso_byte", m0, vecs[v].exp_mi);
      check("vec_rx_data", rx_data, vecs[v].mo);
      check("vec_rx_valid_count", rx_cnt - rx0, 1);
      check("vec_underrun_count", unr_cnt - u0, vecs[v].exp_unr);
      check("vec_tx_ready_after", tx_ready, 1);
      check("vec_miso_oe_idle", miso_oe, 0);
      check("vec_busy_idle", busy, 0);
    end

    // Two-byte frame with a reload at the byte boundary.
    rx0 = rx_cnt; u0 = unr_cnt;
    load(8'h81);
    cs_n = 1'b0;
    xfer_byte(8'h11, 1'b0, 1'b1, 8'h7E, m0);
    xfer_byte(8'h22, 1'b1, 1'b0, 8'h00, m1);
    end_frame_seq();
    check("two_byte_miso0", m0, 8'h81);
    check("two_byte_miso1", m1, 8'h7E);
    check("two_byte_rx_count", rx_cnt - rx0, 2);
    check("two_byte_underrun", unr_cnt - u0, 0);
    check("two_byte_rx_last", rx_data, 8'h22);

    // A load on the same cycle as entry into ACTIVE with an empty holding reg.
    u0 = unr_cnt;
    cs_n = 1'b0;
    k = 0;
    @(negedge clk);
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("entry_busy_seen", busy, 1);
    tx_data = 8'hC3;
    tx_load = 1'b1;
    @(posedge clk);
    #1;
    tx_load = 1'b0;
    xfer_byte(8'h69, 1'b1, 1'b0, 8'h00, m0);
    end_frame_seq();
    check("entry_load_miso", m0, 8'h00);
    check("entry_load_underrun", unr_cnt - u0, 1);
    check("entry_load_kept", tx_ready, 0);
    u0 = unr_cnt;
    cs_n = 1'b0;
    xfer_byte(8'h96, 1'b1, 1'b0, 8'h00, m0);
    end_frame_seq();
    check("entry_load_next_frame", m0, 8'hC3);
    check("entry_load_next_underrun", unr_cnt - u0, 0);

    // Frame aborted after 5 sclk edges.
    rx0 = rx_cnt;
    load(8'h5A);
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int e = 0; e < 5; e++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      wait_clks(HALF);
    end
    check("abort_oe_active", miso_oe, 1);
    cs_n = 1'b1;
    wait_clks(4);
    check("abort_oe_off", miso_oe, 0);
    check("abort_miso_low", miso, 0);
    sclk = 1'b0;
    wait_clks(HALF);
    check("abort_no_rx", rx_cnt - rx0, 0);
    load(8'hE7);
    cs_n = 1'b0;
    xfer_byte(8'hD2, 1'b1, 1'b0, 8'h00, m0);
    end_frame_seq();
    check("abort_next_miso", m0, 8'hE7);
    check("abort_next_rx", rx_data, 8'hD2);

    // sclk activity while deselected.
    rx0 = rx_cnt;
    for (int e = 0; e < 20; e++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      wait_clks(HALF);
    end
    check("desel_no_rx", rx_cnt - rx0, 0);
    check("desel_oe", miso_oe, 0);
    check("desel_cnt", dut.cnt_q, 0);

    // Reset in the middle of a byte, with cs_n held low through the reset.
    load(8'h66);
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int e = 0; e < 7; e++) begin
      sclk = ~sclk;
      wait_clks(HALF);
    end
    rst = 1'b1;
    wait_clks(1);
    check("midrst_miso", miso, 0);
    check("midrst_oe", miso_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_underrun", tx_underrun, 0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    rx0 = rx_cnt; u0 = unr_cnt;
    for (int e = 0; e < 9; e++) begin
      sclk = ~sclk;
      wait_clks(HALF);
    end
    check("postrst_no_entry_oe", miso_oe, 0);
    check("postrst_no_rx", rx_cnt - rx0, 0);
    check("postrst_no_underrun", unr_cnt - u0, 0);
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clks(8);
    load(8'h99);
    cs_n = 1'b0;
    xfer_byte(8'h4B, 1'b1, 1'b0, 8'h00, m0);
    end_frame_seq();
    check("postrst_miso", m0, 8'h99);
    check("postrst_rx", rx_data, 8'h4B);

    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
